// File: rtl/spi_key_cmd_decoder.sv
// Command decoder behind an SPI byte slave. It decodes one command byte per chip-select
// frame. It streams key snapshots, the config register, the device ID or the status byte
// back through the slave's din.
module spi_key_cmd_decoder #(
  parameter int unsigned NUM_KEYS = 64,
  parameter logic [7:0]  ID_BYTE0 = 8'h4E,
  parameter logic [7:0]  ID_BYTE1 = 8'h4B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cs_n,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_byte,
  output logic [7:0]          o_tx_byte,
  input  logic [NUM_KEYS-1:0] i_key_state,
  output logic [7:0]          o_cfg,
  output logic                o_cfg_we,
  output logic                o_err_sticky
);

  localparam int unsigned KEY_BYTES = (NUM_KEYS + 7) / 8;
  localparam int unsigned MAX_LEN   = (KEY_BYTES > 2) ? KEY_BYTES : 2;
  // The index can reach length+1 for an instant before it saturates, so size it for that.
  localparam int unsigned IDX_W     = $clog2(MAX_LEN + 2);

  localparam logic [7:0] CmdReadKeys = 8'h01;
  localparam logic [7:0] CmdReadCfg  = 8'h41;
  localparam logic [7:0] CmdReadId   = 8'h9F;
  localparam logic [7:0] CmdWriteCfg = 8'h40;
  localparam logic [7:0] CmdClrStat  = 8'h06;

  typedef enum logic [1:0] {StIdle, StStream, StWrArg, StDiscard} state_e;
  typedef enum logic [1:0] {SrcKeys, SrcCfg, SrcId} src_e;

  state_e                r_state, w_state_next;
  src_e                  r_src, w_src_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [7:0]            r_tx_byte, w_tx_next;
  logic [7:0]            r_cfg, w_cfg_next;
  logic                  r_cfg_we, w_cfg_we_next;
  logic                  r_err_sticky, w_err_next;
  logic                  r_change_pending, w_cp_next;
  logic [NUM_KEYS-1:0]   r_snap, w_snap_next;
  logic                  r_cs_meta, r_cs_s;

  logic [7:0]            w_status;
  logic [KEY_BYTES*8-1:0] w_snap_pad;
  logic [7:0]            w_live_byte0;
  logic [7:0]            w_key_byte;
  logic [7:0]            w_src_byte;
  logic [IDX_W-1:0]      w_src_len;
  logic [IDX_W-1:0]      w_nidx;

  assign w_status     = {6'b0, r_err_sticky, r_change_pending};
  assign o_tx_byte    = r_tx_byte;
  assign o_cfg        = r_cfg;
  assign o_cfg_we     = r_cfg_we;
  assign o_err_sticky = r_err_sticky;
  assign w_nidx       = r_idx + 1'b1;

  // Two-flop synchronizer for the raw chip select; resets to deselected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cs_meta <= 1'b1;
      r_cs_s    <= 1'b1;
    end else begin
      r_cs_meta <= i_cs_n;
      r_cs_s    <= r_cs_meta;
    end
  end

  // Zero-pad the snapshot to whole bytes and pick out key byte 0 of the live key levels.
  always_comb begin
    w_snap_pad = '0;
    w_snap_pad[NUM_KEYS-1:0] = r_snap;
    w_live_byte0 = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b < NUM_KEYS) w_live_byte0[b] = i_key_state[b];
    end
  end

  // Byte of the active stream source at the next index, plus that source's length.
  always_comb begin
    w_key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (w_nidx == IDX_W'(b)) w_key_byte = w_snap_pad[b*8 +: 8];
    end
    case (r_src)
      SrcKeys: begin
        w_src_len  = IDX_W'(KEY_BYTES);
        w_src_byte = w_key_byte;
      end
      SrcCfg: begin
        w_src_len  = IDX_W'(1);
        w_src_byte = (w_nidx == '0) ? r_cfg : 8'h00;
      end
      SrcId: begin
        w_src_len  = IDX_W'(2);
        w_src_byte = (w_nidx == '0) ? ID_BYTE0 : ((w_nidx == IDX_W'(1)) ? ID_BYTE1 : 8'h00);
      end
      default: begin
        w_src_len  = '0;
        w_src_byte = 8'h00;
      end
    endcase
  end

  // Next-state logic: deselect has priority, then command decode and streaming per state.
  always_comb begin
    w_state_next  = r_state;
    w_src_next    = r_src;
    w_idx_next    = r_idx;
    w_tx_next     = r_tx_byte;
    w_cfg_next    = r_cfg;
    w_cfg_we_next = 1'b0;
    w_err_next    = r_err_sticky;
    w_snap_next   = r_snap;
    w_cp_next     = r_change_pending | (i_key_state != r_snap);

    if (r_cs_s) begin
      // Deselected: any in-flight command is abandoned and the rx byte is dropped.
      w_state_next = StIdle;
      w_idx_next   = '0;
      w_tx_next    = w_status;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_tx_next = w_status;
          if (i_rx_valid) begin
            case (i_rx_byte)
              CmdReadKeys: begin
                w_snap_next  = i_key_state;
                w_cp_next    = 1'b0;
                w_idx_next   = '0;
                w_src_next   = SrcKeys;
                w_tx_next    = w_live_byte0;
                w_state_next = StStream;
              end
              CmdReadCfg: begin
                w_idx_next   = '0;
                w_src_next   = SrcCfg;
                w_tx_next    = r_cfg;
                w_state_next = StStream;
              end
              CmdReadId: begin
                w_idx_next   = '0;
                w_src_next   = SrcId;
                w_tx_next    = ID_BYTE0;
                w_state_next = StStream;
              end
              CmdWriteCfg: begin
                w_tx_next    = 8'h00;
                w_state_next = StWrArg;
              end
              CmdClrStat: begin
                w_err_next   = 1'b0;
                w_tx_next    = 8'h00;
                w_state_next = StDiscard;
              end
              default: begin
                w_err_next   = 1'b1;
                w_tx_next    = 8'hFF;
                w_state_next = StDiscard;
              end
            endcase
          end
        end
        StStream: begin
          if (i_rx_valid) begin
            if (w_nidx >= w_src_len) begin
              w_idx_next = w_src_len;
              w_tx_next  = 8'h00;
            end else begin
              w_idx_next = w_nidx;
              w_tx_next  = w_src_byte;
            end
          end
        end
        StWrArg: begin
          if (i_rx_valid) begin
            w_cfg_next    = i_rx_byte;
            w_cfg_we_next = 1'b1;
            w_state_next  = StDiscard;
          end
        end
        StDiscard: begin
          // Hold tx_byte until the host deselects.
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= StIdle;
      r_src            <= SrcKeys;
      r_idx            <= '0;
      r_tx_byte        <= 8'h00;
      r_cfg            <= 8'h00;
      r_cfg_we         <= 1'b0;
      r_err_sticky     <= 1'b0;
      r_change_pending <= 1'b0;
      r_snap           <= '0;
    end else begin
      r_state          <= w_state_next;
      r_src            <= w_src_next;
      r_idx            <= w_idx_next;
      r_tx_byte        <= w_tx_next;
      r_cfg            <= w_cfg_next;
      r_cfg_we         <= w_cfg_we_next;
      r_err_sticky     <= w_err_next;
      r_change_pending <= w_cp_next;
      r_snap           <= w_snap_next;
    end
  end

endmodule

// File: tb/tb_spi_key_cmd_decoder.sv
// Directed bench for spi_key_cmd_decoder. It drives SPI frames as byte strobes and models
// the slave's din preload, so each MISO byte is the tx_byte value at the preceding strobe.
module tb_spi_key_cmd_decoder;

  logic        clk;
  logic        rst;
  logic        i_cs_n;
  logic        i_rx_valid;
  logic [7:0]  i_rx_byte;
  logic [7:0]  o_tx_byte;
  logic [63:0] i_key_state;
  logic [7:0]  o_cfg;
  logic        o_cfg_we;
  logic        o_err_sticky;

  int passed;
  int total;
  int we_cnt;

  logic [7:0] f_mosi [16];
  logic [7:0] f_miso [17];

  spi_key_cmd_decoder #(
    .NUM_KEYS (64),
    .ID_BYTE0 (8'h4E),
    .ID_BYTE1 (8'h4B)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cs_n       (i_cs_n),
    .i_rx_valid   (i_rx_valid),
    .i_rx_byte    (i_rx_byte),
    .o_tx_byte    (o_tx_byte),
    .i_key_state  (i_key_state),
    .o_cfg        (o_cfg),
    .o_cfg_we     (o_cfg_we),
    .o_err_sticky (o_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cfg_we pulses.
  always @(posedge clk) if (o_cfg_we === 1'b1) we_cnt = we_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The slave latches din for the next byte at the same moment it pulses done.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] miso_next);
    miso_next  = o_tx_byte;
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    tick(1);
    i_rx_valid = 1'b0;
    i_rx_byte  = 8'h00;
    tick(3);
  endtask

  task automatic run_frame(input int n);
    logic [7:0] m;
    i_cs_n = 1'b0;
    tick(4);
    f_miso[0] = o_tx_byte;
    for (int k = 0; k < n; k++) begin
      send_byte(f_mosi[k], m);
      f_miso[k+1] = m;
    end
    f_miso[n+1] = o_tx_byte;
    tick(2);
    i_cs_n = 1'b1;
    tick(4);
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 16; k++) f_mosi[k] = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_cs_n = 1'b1; i_rx_valid = 1'b0; i_rx_byte = 8'h00; i_key_state = '0;
    tick(3);
    total++; if (o_tx_byte !== 8'h00) $display("FAIL reset_tx got %h exp 00", o_tx_byte); else passed++;
    total++; if (o_cfg !== 8'h00) $display("FAIL reset_cfg got %h exp 00", o_cfg); else passed++;
    total++; if (o_err_sticky !== 1'b0) $display("FAIL reset_err got %b exp 0", o_err_sticky); else passed++;
    total++; if (o_cfg_we !== 1'b0) $display("FAIL reset_cfg_we got %b exp 0", o_cfg_we); else passed++;
    rst = 1'b1;
    tick(2);
    total++; if (o_tx_byte !== 8'h00) $display("FAIL idle_status got %h exp 00", o_tx_byte); else passed++;
    i_key_state = 64'h8;
    tick(3);
    total++; if (o_tx_byte !== 8'h01) $display("FAIL change_status got %h exp 01", o_tx_byte); else passed++;
  endtask

  task automatic test_read_keys();
    logic [7:0] exp;
    i_key_state = 64'h0807060504030201;
    tick(2);
    clear_frame();
    f_mosi[0] = 8'h01;
    run_frame(11);
    for (int k = 0; k <= 11; k++) begin
      if (k < 2)       exp = 8'h01;
      else if (k < 10) exp = 8'(k - 1);
      else             exp = 8'h00;
      total++;
      if (f_miso[k] !== exp) $display("FAIL keys_miso[%0d] got %h exp %h", k, f_miso[k], exp);
      else passed++;
    end
    total++; if (o_tx_byte !== 8'h00) $display("FAIL keys_cp_clear got %h exp 00", o_tx_byte); else passed++;
  endtask

  task automatic test_cfg();
    we_cnt = 0;
    clear_frame();
    f_mosi[0] = 8'h40; f_mosi[1] = 8'hA5;
    run_frame(2);
    total++; if (o_cfg !== 8'hA5) $display("FAIL cfg_write got %h exp a5", o_cfg); else passed++;
    total++; if (we_cnt !== 1) $display("FAIL cfg_we_pulses got %0d exp 1", we_cnt); else passed++;
    clear_frame();
    f_mosi[0] = 8'h41;
    run_frame(4);
    total++; if (f_miso[0] !== 8'h00) $display("FAIL cfg_miso0 got %h exp 00", f_miso[0]); else passed++;
    total++; if (f_miso[1] !== 8'h00) $display("FAIL cfg_miso1 got %h exp 00", f_miso[1]); else passed++;
    total++; if (f_miso[2] !== 8'hA5) $display("FAIL cfg_miso2 got %h exp a5", f_miso[2]); else passed++;
    total++; if (f_miso[3] !== 8'h00) $display("FAIL cfg_miso3 got %h exp 00", f_miso[3]); else passed++;
    total++; if (f_miso[4] !== 8'h00) $display("FAIL cfg_miso4 got %h exp 00", f_miso[4]); else passed++;
  endtask

  task automatic test_id_unknown();
    clear_frame();
    f_mosi[0] = 8'h9F;
    run_frame(5);
    total++; if (f_miso[2] !== 8'h4E) $display("FAIL id_miso2 got %h exp 4e", f_miso[2]); else passed++;
    total++; if (f_miso[3] !== 8'h4B) $display("FAIL id_miso3 got %h exp 4b", f_miso[3]); else passed++;
    total++; if (f_miso[4] !== 8'h00) $display("FAIL id_miso4 got %h exp 00", f_miso[4]); else passed++;
    total++; if (f_miso[5] !== 8'h00) $display("FAIL id_miso5 got %h exp 00", f_miso[5]); else passed++;
    clear_frame();
    f_mosi[0] = 8'h77;
    run_frame(3);
    total++; if (f_miso[1] !== 8'h00) $display("FAIL unk_miso1 got %h exp 00", f_miso[1]); else passed++;
    total++; if (f_miso[2] !== 8'hFF) $display("FAIL unk_miso2 got %h exp ff", f_miso[2]); else passed++;
    total++; if (f_miso[3] !== 8'hFF) $display("FAIL unk_miso3 got %h exp ff", f_miso[3]); else passed++;
    total++; if (o_err_sticky !== 1'b1) $display("FAIL unk_err got %b exp 1", o_err_sticky); else passed++;
    total++; if (o_tx_byte !== 8'h02) $display("FAIL unk_status got %h exp 02", o_tx_byte); else passed++;
  endtask

  task automatic test_abort_write();
    we_cnt = 0;
    clear_frame();
    f_mosi[0] = 8'h40;
    run_frame(1);
    total++; if (o_cfg !== 8'hA5) $display("FAIL abort_cfg got %h exp a5", o_cfg); else passed++;
    total++; if (we_cnt !== 0) $display("FAIL abort_cfg_we got %0d exp 0", we_cnt); else passed++;
    clear_frame();
    f_mosi[0] = 8'h41;
    run_frame(3);
    total++; if (f_miso[0] !== 8'h02) $display("FAIL abort_next_miso0 got %h exp 02", f_miso[0]); else passed++;
    total++; if (f_miso[2] !== 8'hA5) $display("FAIL abort_next_miso2 got %h exp a5", f_miso[2]); else passed++;
  endtask

  task automatic test_clear_status();
    clear_frame();
    f_mosi[0] = 8'h06;
    run_frame(2);
    total++; if (f_miso[2] !== 8'h00) $display("FAIL clr_miso2 got %h exp 00", f_miso[2]); else passed++;
    total++; if (o_err_sticky !== 1'b0) $display("FAIL clr_err got %b exp 0", o_err_sticky); else passed++;
    total++; if (o_tx_byte !== 8'h00) $display("FAIL clr_status got %h exp 00", o_tx_byte); else passed++;
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] m;
    clear_frame();
    f_mosi[0] = 8'h33;
    run_frame(1);
    i_key_state = 64'hFF;
    i_cs_n = 1'b0;
    tick(4);
    send_byte(8'h01, m);
    send_byte(8'h00, m);
    total++; if (o_tx_byte !== 8'h00) $display("FAIL mid_stream_tx got %h exp 00", o_tx_byte); else passed++;
    send_byte(8'h00, m);
    total++; if (m !== 8'h00) $display("FAIL mid_stream_miso got %h exp 00", m); else passed++;
    rst = 1'b0;
    tick(1);
    total++; if (o_tx_byte !== 8'h00) $display("FAIL rst_mid_tx got %h exp 00", o_tx_byte); else passed++;
    total++; if (o_cfg !== 8'h00) $display("FAIL rst_mid_cfg got %h exp 00", o_cfg); else passed++;
    total++; if (o_err_sticky !== 1'b0) $display("FAIL rst_mid_err got %b exp 0", o_err_sticky); else passed++;
    total++; if (o_cfg_we !== 1'b0) $display("FAIL rst_mid_cfg_we got %b exp 0", o_cfg_we); else passed++;
    rst = 1'b1;
    i_cs_n = 1'b1;
    tick(4);
    total++; if (o_tx_byte !== 8'h01) $display("FAIL post_rst_status got %h exp 01", o_tx_byte); else passed++;
  endtask

  // Deselect reaching the synchronized chip select in the same cycle as a strobe drops the byte.
  task automatic test_deselect_race();
    logic [7:0] m;
    we_cnt = 0;
    i_cs_n = 1'b0;
    tick(4);
    send_byte(8'h40, m);
    i_cs_n = 1'b1;
    tick(2);
    i_rx_valid = 1'b1;
    i_rx_byte  = 8'h3C;
    tick(1);
    i_rx_valid = 1'b0;
    i_rx_byte  = 8'h00;
    tick(3);
    total++; if (o_cfg !== 8'h00) $display("FAIL race_cfg got %h exp 00", o_cfg); else passed++;
    total++; if (we_cnt !== 0) $display("FAIL race_cfg_we got %0d exp 0", we_cnt); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    we_cnt = 0;
    test_reset();
    test_read_keys();
    test_cfg();
    test_id_unknown();
    test_abort_write();
    test_clear_status();
    test_reset_mid_stream();
    test_deselect_race();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
